// File: rtl/image_pkg.sv
// Shared types and BMP header constants for the image_write sink.
// Contents: FSM state enum, fixed BMP header sizes/values, header field byte offsets,
// and a helper that extracts one byte of a little-endian 32-bit header field.
package image_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_HEADER = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned BMP_HDR_BYTES = 54;
    localparam int unsigned DIB_SIZE      = 40;
    localparam int unsigned BPP           = 24;
    localparam int unsigned PPM_RES       = 2835;
    localparam int unsigned PLANES        = 1;
    localparam int unsigned WORD_W        = 48;

    // Byte offsets of the header fields within the 54-byte header
    localparam int unsigned OFF_SIGNATURE   = 0;
    localparam int unsigned OFF_FILE_SIZE   = 2;
    localparam int unsigned OFF_RESERVED    = 6;
    localparam int unsigned OFF_DATA_OFFSET = 10;
    localparam int unsigned OFF_DIB_SIZE    = 14;
    localparam int unsigned OFF_WIDTH       = 18;
    localparam int unsigned OFF_HEIGHT      = 22;
    localparam int unsigned OFF_PLANES      = 26;
    localparam int unsigned OFF_BPP         = 28;
    localparam int unsigned OFF_COMPRESSION = 30;
    localparam int unsigned OFF_IMAGE_SIZE  = 34;
    localparam int unsigned OFF_XRES        = 38;
    localparam int unsigned OFF_YRES        = 42;
    localparam int unsigned OFF_COLOURS     = 46;
    localparam int unsigned OFF_IMPORTANT   = 50;

    // Byte of a little-endian 32-bit value placed at 'off'; zero outside its four bytes
    function automatic logic [7:0] le_field_byte(input logic [5:0]  addr,
                                                 input logic [5:0]  off,
                                                 input logic [31:0] value);
        logic [5:0] rel;
        logic [7:0] result;
        rel    = addr - off;
        result = 8'h00;
        if (rel < 6'd4) begin
            case (rel[1:0])
                2'd0:    result = value[7:0];
                2'd1:    result = value[15:8];
                2'd2:    result = value[23:16];
                default: result = value[31:24];
            endcase
        end
        return result;
    endfunction

endpackage

// File: rtl/image_write_bmp_header_rom.sv
// bmp_header_rom: constant 54-byte BMP header, combinational lookup.
// Ports: addr[5:0] header byte offset in, data[7:0] header byte out.
// Fields occupy disjoint byte ranges and read as zero elsewhere, so the byte is the OR of all fields.
module bmp_header_rom
    import image_pkg::*;
#(
    parameter int unsigned WIDTH  = 768,
    parameter int unsigned HEIGHT = 512
) (
    input  logic [5:0] addr,
    output logic [7:0] data
);

    localparam logic [31:0] IMAGE_SIZE = 32'(WIDTH * HEIGHT * 3);
    localparam logic [31:0] FILE_SIZE  = 32'(BMP_HDR_BYTES + WIDTH * HEIGHT * 3);

    always_comb begin
        data = 8'h00;
        // 'B','M' in the low two bytes; the upper two overlap the file size and stay zero
        data = data | le_field_byte(addr, 6'(OFF_SIGNATURE),   32'h0000_4D42);
        data = data | le_field_byte(addr, 6'(OFF_FILE_SIZE),   FILE_SIZE);
        data = data | le_field_byte(addr, 6'(OFF_RESERVED),    32'h0);
        data = data | le_field_byte(addr, 6'(OFF_DATA_OFFSET), 32'(BMP_HDR_BYTES));
        data = data | le_field_byte(addr, 6'(OFF_DIB_SIZE),    32'(DIB_SIZE));
        data = data | le_field_byte(addr, 6'(OFF_WIDTH),       32'(WIDTH));
        data = data | le_field_byte(addr, 6'(OFF_HEIGHT),      32'(HEIGHT));
        // Planes and bpp are adjacent 16-bit fields, packed as one 32-bit word
        data = data | le_field_byte(addr, 6'(OFF_PLANES),      {16'(BPP), 16'(PLANES)});
        data = data | le_field_byte(addr, 6'(OFF_COMPRESSION), 32'h0);
        data = data | le_field_byte(addr, 6'(OFF_IMAGE_SIZE),  IMAGE_SIZE);
        data = data | le_field_byte(addr, 6'(OFF_XRES),        32'(PPM_RES));
        data = data | le_field_byte(addr, 6'(OFF_YRES),        32'(PPM_RES));
        data = data | le_field_byte(addr, 6'(OFF_COLOURS),     32'h0);
        data = data | le_field_byte(addr, 6'(OFF_IMPORTANT),   32'h0);
    end

endmodule

// File: rtl/image_write.sv
// image_write: sink for a two-pixels-per-clock RGB stream.
// Each HSYNC beat is packed into one 48-bit word {R1,G1,B1,R0,G0,B0} and written at its
// bottom-up BMP word address; after the last beat the 54-byte BMP header is emitted on the
// byte port, then write_done pulses for one cycle.
// Ports:
//   HCLK, HRESETn            clock, synchronous active-low reset
//   VSYNC, HSYNC             frame-start qualifier, beat valid
//   DATA_R0..B0, DATA_R1..B1 even / odd pixel of the beat
//   mem_we/mem_addr/mem_wdata frame-memory write port (registered)
//   hdr_we/hdr_addr/hdr_byte  header byte port (registered)
//   write_done               one-cycle pulse when frame and header are complete
//   frame_err                sticky framing error, cleared on the first beat of a frame
module image_write
    import image_pkg::*;
#(
    parameter int unsigned WIDTH  = 768,
    parameter int unsigned HEIGHT = 512,
    parameter int unsigned ADDR_W = 18
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              VSYNC,
    input  logic              HSYNC,
    input  logic [7:0]        DATA_R0,
    input  logic [7:0]        DATA_G0,
    input  logic [7:0]        DATA_B0,
    input  logic [7:0]        DATA_R1,
    input  logic [7:0]        DATA_G1,
    input  logic [7:0]        DATA_B1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [47:0]       mem_wdata,
    output logic              hdr_we,
    output logic [5:0]        hdr_addr,
    output logic [7:0]        hdr_byte,
    output logic              write_done,
    output logic              frame_err
);

    localparam int unsigned COLS       = WIDTH / 2;
    localparam int unsigned COL_W      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned LAST_COL   = COLS - 1;
    localparam int unsigned LAST_ROW   = HEIGHT - 1;
    // Row 0 lands on the last line of the bottom-up BMP image
    localparam int unsigned ADDR_START = (HEIGHT - 1) * COLS;

    state_t              state;
    logic [ROW_W-1:0]    row;
    logic [COL_W-1:0]    col;
    logic [ADDR_W-1:0]   addr;
    logic [5:0]          hdr_cnt;
    logic [7:0]          rom_data;
    logic                line_end;
    logic                frame_end;

    bmp_header_rom #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_header_rom (
        .addr (hdr_cnt),
        .data (rom_data)
    );

    assign line_end  = (col == COL_W'(LAST_COL));
    assign frame_end = line_end && (row == ROW_W'(LAST_ROW));

    // Frame FSM, row/col counters and running write address
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state      <= ST_IDLE;
            row        <= '0;
            col        <= '0;
            addr       <= ADDR_W'(ADDR_START);
            hdr_cnt    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hdr_we     <= 1'b0;
            hdr_addr   <= '0;
            hdr_byte   <= '0;
            write_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            hdr_we     <= 1'b0;
            write_done <= 1'b0;

            case (state)
                ST_IDLE, ST_DATA: begin
                    if (state == ST_DATA && VSYNC) begin
                        // Frame restarted before it completed: drop progress, no header
                        frame_err <= 1'b1;
                        row       <= '0;
                        col       <= '0;
                        addr      <= ADDR_W'(ADDR_START);
                        state     <= ST_IDLE;
                    end else if (HSYNC) begin
                        if (state == ST_IDLE) begin
                            frame_err <= 1'b0;
                        end
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};
                        state     <= ST_DATA;
                        if (frame_end) begin
                            row     <= '0;
                            col     <= '0;
                            addr    <= ADDR_W'(ADDR_START);
                            hdr_cnt <= '0;
                            state   <= ST_HEADER;
                        end else if (line_end) begin
                            // Next line sits one line lower in memory: +1 then -WIDTH
                            row  <= row + ROW_W'(1);
                            col  <= '0;
                            addr <= addr + ADDR_W'(1) - ADDR_W'(WIDTH);
                        end else begin
                            col  <= col + COL_W'(1);
                            addr <= addr + ADDR_W'(1);
                        end
                    end
                end

                ST_HEADER: begin
                    hdr_we   <= 1'b1;
                    hdr_addr <= hdr_cnt;
                    hdr_byte <= rom_data;
                    // Beats are not accepted while the header is streaming out
                    if (HSYNC) begin
                        frame_err <= 1'b1;
                    end
                    if (hdr_cnt == 6'(BMP_HDR_BYTES - 1)) begin
                        hdr_cnt <= '0;
                        state   <= ST_DONE;
                    end else begin
                        hdr_cnt <= hdr_cnt + 6'd1;
                    end
                end

                ST_DONE: begin
                    write_done <= 1'b1;
                    state      <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_write.sv
// Directed self-checking bench for image_write.
// Three builds share clock, reset and pixel data: a = 768x512 (default), b = 16x8, c = 4x2.
module tb_image_write;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  r0, g0, b0, r1, g1, b1;
    logic        a_vsync, a_hsync, b_vsync, b_hsync, c_vsync, c_hsync;

    logic        a_mem_we, a_hdr_we, a_done, a_err;
    logic [17:0] a_mem_addr;
    logic [47:0] a_mem_wdata;
    logic [5:0]  a_hdr_addr;
    logic [7:0]  a_hdr_byte;

    logic        b_mem_we, b_hdr_we, b_done, b_err;
    logic [5:0]  b_mem_addr;
    logic [47:0] b_mem_wdata;
    logic [5:0]  b_hdr_addr;
    logic [7:0]  b_hdr_byte;

    logic        c_mem_we, c_hdr_we, c_done, c_err;
    logic [1:0]  c_mem_addr;
    logic [47:0] c_mem_wdata;
    logic [5:0]  c_hdr_addr;
    logic [7:0]  c_hdr_byte;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    image_write #(.WIDTH(768), .HEIGHT(512), .ADDR_W(18)) dut_a (
        .HCLK(clk), .HRESETn(rst_n), .VSYNC(a_vsync), .HSYNC(a_hsync),
        .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0), .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .hdr_we(a_hdr_we), .hdr_addr(a_hdr_addr), .hdr_byte(a_hdr_byte),
        .write_done(a_done), .frame_err(a_err)
    );

    image_write #(.WIDTH(16), .HEIGHT(8), .ADDR_W(6)) dut_b (
        .HCLK(clk), .HRESETn(rst_n), .VSYNC(b_vsync), .HSYNC(b_hsync),
        .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0), .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .hdr_we(b_hdr_we), .hdr_addr(b_hdr_addr), .hdr_byte(b_hdr_byte),
        .write_done(b_done), .frame_err(b_err)
    );

    image_write #(.WIDTH(4), .HEIGHT(2), .ADDR_W(2)) dut_c (
        .HCLK(clk), .HRESETn(rst_n), .VSYNC(c_vsync), .HSYNC(c_hsync),
        .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0), .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
        .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata),
        .hdr_we(c_hdr_we), .hdr_addr(c_hdr_addr), .hdr_byte(c_hdr_byte),
        .write_done(c_done), .frame_err(c_err)
    );

    // Pixel values of beat k: six consecutive byte values starting at k
    task automatic set_pixels(input int k);
        r0 = 8'(k);
        g0 = 8'(k + 1);
        b0 = 8'(k + 2);
        r1 = 8'(k + 3);
        g1 = 8'(k + 4);
        b1 = 8'(k + 5);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_vsync = 1'b0; a_hsync = 1'b0;
        b_vsync = 1'b0; b_hsync = 1'b0;
        c_vsync = 1'b0; c_hsync = 1'b0;
        set_pixels(0);
        repeat (2) @(negedge clk);
        checks++;
        if ({a_mem_we, a_mem_addr, a_mem_wdata, a_hdr_we, a_hdr_addr, a_hdr_byte, a_done, a_err} !== '0)
            $display("FAIL reset_a: outputs %h, want all 0",
                     {a_mem_we, a_mem_addr, a_mem_wdata, a_hdr_we, a_hdr_addr, a_hdr_byte, a_done, a_err});
        else passed++;
        checks++;
        if ({b_mem_we, b_mem_addr, b_mem_wdata, b_hdr_we, b_hdr_addr, b_hdr_byte, b_done, b_err} !== '0)
            $display("FAIL reset_b: outputs %h, want all 0",
                     {b_mem_we, b_mem_addr, b_mem_wdata, b_hdr_we, b_hdr_addr, b_hdr_byte, b_done, b_err});
        else passed++;
        checks++;
        if ({c_mem_we, c_mem_addr, c_mem_wdata, c_hdr_we, c_hdr_addr, c_hdr_byte, c_done, c_err} !== '0)
            $display("FAIL reset_c: outputs %h, want all 0",
                     {c_mem_we, c_mem_addr, c_mem_wdata, c_hdr_we, c_hdr_addr, c_hdr_byte, c_done, c_err});
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // First beat of a 768x512 frame: address of the last BMP line, B0 in the lowest byte
    task automatic test_first_beat();
        a_hsync = 1'b1;
        r0 = 8'd11; g0 = 8'd22; b0 = 8'd33; r1 = 8'd44; g1 = 8'd55; b1 = 8'd66;
        @(negedge clk);
        a_hsync = 1'b0;
        checks++;
        if (a_mem_we !== 1'b1) $display("FAIL first_we: got %b want 1", a_mem_we);
        else passed++;
        checks++;
        if (a_mem_addr !== 18'd196224) $display("FAIL first_addr: got %0d want 196224", a_mem_addr);
        else passed++;
        checks++;
        if (a_mem_wdata !== 48'h2C3742_0B1621)
            $display("FAIL first_wdata: got %h want 2c37420b1621", a_mem_wdata);
        else passed++;
        @(negedge clk);
        checks++;
        if (a_mem_we !== 1'b0) $display("FAIL gap_we: got %b want 0", a_mem_we);
        else passed++;
    endtask

    // Beats 1..999 of the same frame: end of line 0, start of line 1, beat 999
    task automatic test_line_wrap();
        for (int k = 1; k < 1000; k++) begin
            a_hsync = 1'b1;
            set_pixels(k);
            @(negedge clk);
            if (k == 383) begin
                checks++;
                if (a_mem_addr !== 18'd196607) $display("FAIL line0_end: got %0d want 196607", a_mem_addr);
                else passed++;
            end
            if (k == 384) begin
                checks++;
                if (a_mem_addr !== 18'd195840) $display("FAIL line1_start: got %0d want 195840", a_mem_addr);
                else passed++;
            end
            if (k == 999) begin
                checks++;
                if ({a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 18'd195687, 48'hEAEBEC_E7E8E9})
                    $display("FAIL beat999: got we=%b addr=%0d data=%h want 1 195687 eaebece7e8e9",
                             a_mem_we, a_mem_addr, a_mem_wdata);
                else passed++;
            end
        end
        a_hsync = 1'b0;
    endtask

    task automatic test_vsync_abort_a();
        int seen;
        a_vsync = 1'b1;
        @(negedge clk);
        a_vsync = 1'b0;
        checks++;
        if ({a_err, a_mem_we} !== 2'b10) $display("FAIL abort_a_err: got err=%b we=%b want 1 0", a_err, a_mem_we);
        else passed++;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (a_hdr_we || a_done) seen++;
        end
        checks++;
        if (seen != 0) $display("FAIL abort_a_quiet: %0d header/done cycles, want 0", seen);
        else passed++;
        checks++;
        if (a_err !== 1'b1) $display("FAIL abort_a_sticky: got %b want 1", a_err);
        else passed++;
        // New frame: first beat clears the error and starts from the top address again
        a_hsync = 1'b1;
        set_pixels(5);
        @(negedge clk);
        checks++;
        if ({a_err, a_mem_we, a_mem_addr} !== {1'b0, 1'b1, 18'd196224})
            $display("FAIL restart_a: got err=%b we=%b addr=%0d want 0 1 196224", a_err, a_mem_we, a_mem_addr);
        else passed++;
        repeat (9) @(negedge clk);
    endtask

    // Reset pulse mid-line with HSYNC still high
    task automatic test_reset_midline();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_mem_we, a_mem_addr, a_mem_wdata, a_hdr_we, a_hdr_addr, a_hdr_byte, a_done, a_err} !== '0)
            $display("FAIL midreset_a: outputs %h, want all 0",
                     {a_mem_we, a_mem_addr, a_mem_wdata, a_hdr_we, a_hdr_addr, a_hdr_byte, a_done, a_err});
        else passed++;
        rst_n = 1'b1;
        a_hsync = 1'b0;
        @(negedge clk);
        a_hsync = 1'b1;
        set_pixels(7);
        @(negedge clk);
        a_hsync = 1'b0;
        checks++;
        if ({a_mem_we, a_mem_addr} !== {1'b1, 18'd196224})
            $display("FAIL midreset_restart: got we=%b addr=%0d want 1 196224", a_mem_we, a_mem_addr);
        else passed++;
    endtask

    task automatic test_vsync_abort_b();
        int seen;
        b_hsync = 1'b1;
        for (int k = 0; k < 20; k++) begin
            set_pixels(k);
            @(negedge clk);
        end
        b_hsync = 1'b0;
        b_vsync = 1'b1;
        @(negedge clk);
        b_vsync = 1'b0;
        checks++;
        if (b_err !== 1'b1) $display("FAIL abort_b_err: got %b want 1", b_err);
        else passed++;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (b_hdr_we || b_done) seen++;
        end
        checks++;
        if (seen != 0) $display("FAIL abort_b_quiet: %0d header/done cycles, want 0", seen);
        else passed++;
    endtask

    // Complete 16x8 frame with inter-line gaps, then header and done
    task automatic test_full_frame();
        logic [7:0]  exp_hdr [54];
        logic [63:0] seen;
        logic [47:0] exp_data;
        int          exp_addr;
        int          dup;
        int          stray;
        for (int i = 0; i < 54; i++) exp_hdr[i] = 8'h00;
        exp_hdr[0]  = 8'h42; exp_hdr[1]  = 8'h4D;
        exp_hdr[2]  = 8'hB6; exp_hdr[3]  = 8'h01;   // 54 + 16*8*3 = 438
        exp_hdr[10] = 8'h36; exp_hdr[14] = 8'h28;
        exp_hdr[18] = 8'h10; exp_hdr[22] = 8'h08;
        exp_hdr[26] = 8'h01; exp_hdr[28] = 8'h18;
        exp_hdr[34] = 8'h80; exp_hdr[35] = 8'h01;   // 384
        exp_hdr[38] = 8'h13; exp_hdr[39] = 8'h0B;
        exp_hdr[42] = 8'h13; exp_hdr[43] = 8'h0B;
        seen  = '0;
        dup   = 0;
        stray = 0;
        for (int k = 0; k < 64; k++) begin
            b_hsync = 1'b1;
            set_pixels(k);
            @(negedge clk);
            exp_addr = (7 - k / 8) * 8 + (k % 8);
            exp_data = {8'(k + 3), 8'(k + 4), 8'(k + 5), 8'(k), 8'(k + 1), 8'(k + 2)};
            checks++;
            if ({b_mem_we, b_mem_addr, b_mem_wdata} !== {1'b1, 6'(exp_addr), exp_data})
                $display("FAIL frame_beat%0d: got we=%b addr=%0d data=%h want 1 %0d %h",
                         k, b_mem_we, b_mem_addr, b_mem_wdata, exp_addr, exp_data);
            else passed++;
            if (k == 0) begin
                checks++;
                if (b_err !== 1'b0) $display("FAIL frame_err_clear: got %b want 0", b_err);
                else passed++;
            end
            if (b_mem_we) begin
                if (seen[b_mem_addr]) dup++;
                seen[b_mem_addr] = 1'b1;
            end
            if ((k % 8) == 7 && k != 63) begin
                b_hsync = 1'b0;
                repeat (3 + k / 8) begin
                    @(negedge clk);
                    if (b_mem_we) stray++;
                end
            end
        end
        b_hsync = 1'b0;
        checks++;
        if (seen !== {64{1'b1}} || dup != 0 || stray != 0)
            $display("FAIL frame_coverage: seen=%h dup=%0d stray=%0d want all-ones 0 0", seen, dup, stray);
        else passed++;
        for (int i = 0; i < 54; i++) begin
            @(negedge clk);
            checks++;
            if ({b_hdr_we, b_hdr_addr, b_hdr_byte, b_mem_we} !== {1'b1, 6'(i), exp_hdr[i], 1'b0})
                $display("FAIL hdr_b%0d: got we=%b addr=%0d byte=%h mem_we=%b want 1 %0d %h 0",
                         i, b_hdr_we, b_hdr_addr, b_hdr_byte, b_mem_we, i, exp_hdr[i]);
            else passed++;
        end
        @(negedge clk);
        checks++;
        if ({b_done, b_hdr_we} !== 2'b10) $display("FAIL done_b: got done=%b hdr_we=%b want 1 0", b_done, b_hdr_we);
        else passed++;
        @(negedge clk);
        checks++;
        if (b_done !== 1'b0) $display("FAIL done_b_pulse: got %b want 0", b_done);
        else passed++;
        // Back in IDLE: a new beat starts the next frame at the top address
        b_hsync = 1'b1;
        set_pixels(200);
        @(negedge clk);
        b_hsync = 1'b0;
        checks++;
        if ({b_mem_we, b_mem_addr} !== {1'b1, 6'd56})
            $display("FAIL next_frame_b: got we=%b addr=%0d want 1 56", b_mem_we, b_mem_addr);
        else passed++;
    endtask

    // 4x2 build with HSYNC held high, plus a stray beat during the header
    task automatic test_small_continuous();
        int         exp_c [4];
        logic [7:0] want;
        exp_c = '{2, 3, 0, 1};
        c_hsync = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_pixels(100 + k);
            @(negedge clk);
            checks++;
            if ({c_mem_we, c_mem_addr} !== {1'b1, 2'(exp_c[k])})
                $display("FAIL small_beat%0d: got we=%b addr=%0d want 1 %0d", k, c_mem_we, c_mem_addr, exp_c[k]);
            else passed++;
        end
        for (int i = 0; i < 54; i++) begin
            c_hsync = (i == 10);
            @(negedge clk);
            case (i)
                0:       want = 8'h42;
                1:       want = 8'h4D;
                2:       want = 8'h4E;   // 54 + 4*2*3 = 78
                10:      want = 8'h36;
                14:      want = 8'h28;
                18:      want = 8'h04;
                22:      want = 8'h02;
                26:      want = 8'h01;
                28:      want = 8'h18;
                34:      want = 8'h18;   // 24
                38:      want = 8'h13;
                39:      want = 8'h0B;
                42:      want = 8'h13;
                43:      want = 8'h0B;
                default: want = 8'h00;
            endcase
            checks++;
            if ({c_hdr_we, c_hdr_addr, c_hdr_byte, c_mem_we, c_err} !== {1'b1, 6'(i), want, 1'b0, (i >= 10)})
                $display("FAIL hdr_c%0d: got we=%b addr=%0d byte=%h mem_we=%b err=%b want 1 %0d %h 0 %b",
                         i, c_hdr_we, c_hdr_addr, c_hdr_byte, c_mem_we, c_err, i, want, (i >= 10));
            else passed++;
        end
        c_hsync = 1'b0;
        @(negedge clk);
        checks++;
        if ({c_done, c_hdr_we, c_mem_we} !== 3'b100)
            $display("FAIL done_c: got done=%b hdr_we=%b mem_we=%b want 1 0 0", c_done, c_hdr_we, c_mem_we);
        else passed++;
        @(negedge clk);
        checks++;
        if (c_done !== 1'b0) $display("FAIL done_c_pulse: got %b want 0", c_done);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_first_beat();
        test_line_wrap();
        test_vsync_abort_a();
        test_reset_midline();
        test_vsync_abort_b();
        test_full_frame();
        test_small_continuous();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
